// File: rtl/dbg_dm_if.sv
// DMI request/response channel between a debug transport (master) and dbg_dm (slave).
interface dbg_dm_if #(
  parameter int ABITS = 6
);
  logic             dmi_req_valid;
  logic             dmi_req_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [1:0]       dmi_req_op;
  logic [31:0]      dmi_req_data;
  logic             dmi_resp_valid;
  logic             dmi_resp_ready;
  logic [31:0]      dmi_resp_data;
  logic             dmi_resp_err;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready,
    input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_err
  );
  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready,
    output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_err
  );
endinterface

// File: rtl/dbg_dm.sv
// Debug module: DMI register file, halt/reset requests and a one-cycle
// abstract-command sequencer for GPR access while the core is halted.
module dbg_dm #(
  parameter int          ABITS    = 6,
  parameter logic [15:0] GPR_BASE = 16'h1000
) (
  input  logic         clk,
  input  logic         rst,
  dbg_dm_if.slave      dmi,
  output logic         halt_req_o,
  output logic         reset_req_o,
  output logic         reg_wen_o,
  output logic [4:0]   reg_addr_o,
  output logic [31:0]  reg_wdata_o,
  input  logic [31:0]  reg_rdata_i
);
  localparam logic [ABITS-1:0] A_DATA0      = ABITS'(8'h04);
  localparam logic [ABITS-1:0] A_DMCONTROL  = ABITS'(8'h10);
  localparam logic [ABITS-1:0] A_DMSTATUS   = ABITS'(8'h11);
  localparam logic [ABITS-1:0] A_ABSTRACTCS = ABITS'(8'h16);
  localparam logic [ABITS-1:0] A_COMMAND    = ABITS'(8'h17);

  typedef enum logic { D_IDLE, D_RESP } dstate_t;
  typedef enum logic { C_IDLE, C_ACC  } cstate_t;

  dstate_t r_dstate, w_dstate_nxt;
  cstate_t r_cstate, w_cstate_nxt;

  logic        r_dmactive, r_haltreq, r_ndmreset, r_halted;
  logic [31:0] r_data0;
  logic [2:0]  r_cmderr;
  logic [4:0]  r_cmd_reg;
  logic        r_cmd_write;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic             w_accept, w_wr, w_rd, w_busy;
  logic [ABITS-1:0] w_addr;
  logic [31:0]      w_wd, w_rdata;
  logic [15:0]      w_regno;
  logic             w_cwrite, w_transfer, w_in_range, w_cmd_bad;
  logic [7:0]       w_cmdtype;
  logic             w_cmd_wr, w_cmd_start;

  assign w_addr   = dmi.dmi_req_addr;
  assign w_wd     = dmi.dmi_req_data;
  assign w_accept = dmi.dmi_req_valid && (r_dstate == D_IDLE);
  assign w_wr     = w_accept && (dmi.dmi_req_op == 2'd2);
  assign w_rd     = w_accept && (dmi.dmi_req_op == 2'd1);
  assign w_busy   = (r_cstate == C_ACC);

  assign w_regno    = w_wd[15:0];
  assign w_cwrite   = w_wd[16];
  assign w_transfer = w_wd[17];
  assign w_cmdtype  = w_wd[31:24];
  assign w_in_range = (w_regno >= GPR_BASE) && (w_regno <= GPR_BASE + 16'd31);
  assign w_cmd_bad  = (w_cmdtype != 8'd0) || (w_transfer && !w_in_range);
  // While dmactive is low the whole command path is frozen.
  assign w_cmd_wr    = w_wr && (w_addr == A_COMMAND) && r_dmactive;
  assign w_cmd_start = w_cmd_wr && !w_busy && (r_cmderr == 3'd0) && !w_cmd_bad &&
                       r_halted && w_transfer;

  always_comb begin
    w_dstate_nxt = r_dstate;
    case (r_dstate)
      D_IDLE: if (w_accept) w_dstate_nxt = D_RESP;
      D_RESP: if (dmi.dmi_resp_ready) w_dstate_nxt = D_IDLE;
      default: w_dstate_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    w_cstate_nxt = C_IDLE;
    if (r_cstate == C_IDLE && w_cmd_start) w_cstate_nxt = C_ACC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dstate <= D_IDLE;
      r_cstate <= C_IDLE;
    end else begin
      r_dstate <= w_dstate_nxt;
      r_cstate <= w_cstate_nxt;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (w_addr)
        A_DATA0:      w_rdata = r_data0;
        A_DMCONTROL:  w_rdata = {r_haltreq, 29'd0, r_ndmreset, r_dmactive};
        A_DMSTATUS:   w_rdata = {20'd0, ~r_halted, ~r_halted, r_halted, r_halted, 4'd0, 4'd2};
        A_ABSTRACTCS: w_rdata = {19'd0, w_busy, 1'b0, r_cmderr, 8'd0};
        default:      w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_data <= 32'd0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_resp_data <= w_rdata;
      r_resp_err  <= (dmi.dmi_req_op == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmactive  <= 1'b0;
      r_haltreq   <= 1'b0;
      r_ndmreset  <= 1'b0;
      r_halted    <= 1'b0;
      r_data0     <= 32'd0;
      r_cmderr    <= 3'd0;
      r_cmd_reg   <= 5'd0;
      r_cmd_write <= 1'b0;
    end else begin
      // haltreq/ndmreset only take effect in the same write that keeps dmactive set
      if (w_wr && w_addr == A_DMCONTROL) begin
        r_dmactive <= w_wd[0];
        r_haltreq  <= w_wd[0] & w_wd[31];
        r_ndmreset <= w_wd[0] & w_wd[1];
      end
      r_halted <= r_haltreq;

      if (!r_dmactive) begin
        r_data0  <= 32'd0;
        r_cmderr <= 3'd0;
      end else begin
        if (w_busy && !r_cmd_write)
          r_data0 <= reg_rdata_i;
        else if (w_wr && w_addr == A_DATA0 && !w_busy)
          r_data0 <= w_wd;

        if (w_wr && w_addr == A_ABSTRACTCS)
          r_cmderr <= r_cmderr & ~w_wd[10:8];
        else if (w_busy && w_wr && (w_addr == A_DATA0 || w_addr == A_COMMAND))
          r_cmderr <= 3'd1;
        else if (w_cmd_wr && r_cmderr == 3'd0) begin
          if (w_cmd_bad)      r_cmderr <= 3'd2;
          else if (!r_halted) r_cmderr <= 3'd4;
        end
      end

      if (w_cmd_start) begin
        r_cmd_reg   <= w_regno[4:0];
        r_cmd_write <= w_cwrite;
      end
    end
  end

  // Core-side strobes are decoded from state so reset kills them at once.
  assign reg_wen_o   = w_busy && r_cmd_write;
  assign reg_addr_o  = w_busy ? r_cmd_reg : 5'd0;
  assign reg_wdata_o = (w_busy && r_cmd_write) ? r_data0 : 32'd0;

  assign halt_req_o  = r_haltreq;
  assign reset_req_o = r_ndmreset;

  assign dmi.dmi_req_ready  = (r_dstate == D_IDLE);
  assign dmi.dmi_resp_valid = (r_dstate == D_RESP);
  assign dmi.dmi_resp_data  = r_resp_data;
  assign dmi.dmi_resp_err   = r_resp_err;
endmodule

// File: tb/tb_dbg_dm.sv
// Directed bench for dbg_dm: DMI register access, abstract commands and resets.
module tb_dbg_dm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_req, reset_req, reg_wen;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  logic [4:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rd;
  logic        er;

  dbg_dm_if #(.ABITS(6)) bus ();

  dbg_dm #(.ABITS(6), .GPR_BASE(16'h1000)) dut (
    .clk(clk), .rst(rst), .dmi(bus.slave),
    .halt_req_o(halt_req), .reset_req_o(reset_req),
    .reg_wen_o(reg_wen), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
    .reg_rdata_i(reg_rdata)
  );

  always #5 clk = ~clk;

  // GPR file stub: x10 holds a known value, other indices return a tagged pattern.
  assign reg_rdata = (reg_addr == 5'd10) ? 32'h12345678 : {27'h5A5A5A5, reg_addr};

  always @(negedge clk) begin
    if (reg_wen) begin
      wen_cnt++;
      cap_addr  = reg_addr;
      cap_wdata = reg_wdata;
    end
  end

  task automatic dmi_xfer(input logic [5:0] a, input logic [1:0] op, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    bus.dmi_req_valid = 1'b1; bus.dmi_req_addr = a; bus.dmi_req_op = op; bus.dmi_req_data = d;
    n = 0;
    while (!bus.dmi_req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL req_timeout addr=%h got ready=0 want 1", a);
    end
    @(posedge clk); #1;
    bus.dmi_req_valid = 1'b0;
    n = 0;
    while (!bus.dmi_resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h got valid=0 want 1", a);
    end
    rdata = bus.dmi_resp_data;
    err   = bus.dmi_resp_err;
    bus.dmi_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.dmi_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.dmi_req_ready !== 1'b1 || halt_req !== 1'b0 || reset_req !== 1'b0 ||
        reg_wen !== 1'b0 || reg_addr !== 5'd0 || bus.dmi_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b halt=%b rst=%b wen=%b addr=%0d rv=%b want 1 0 0 0 0 0",
               bus.dmi_req_ready, halt_req, reset_req, reg_wen, reg_addr, bus.dmi_resp_valid);
    end
    dmi_xfer(6'h11, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h00000C02 || er !== 1'b0) begin
      errors++; $display("FAIL reset_dmstatus got %h err %b want 00000c02 err 0", rd, er);
    end
  endtask

  task automatic test_halt();
    dmi_xfer(6'h10, 2'd2, 32'h80000001, rd, er);
    checks++;
    if (halt_req !== 1'b1) begin errors++; $display("FAIL halt_req got %b want 1", halt_req); end
    dmi_xfer(6'h11, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h00000302) begin errors++; $display("FAIL halted_dmstatus got %h want 00000302", rd); end
    dmi_xfer(6'h10, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h80000001) begin errors++; $display("FAIL dmcontrol_rd got %h want 80000001", rd); end
  endtask

  task automatic test_gpr_write();
    dmi_xfer(6'h04, 2'd2, 32'hDEADBEEF, rd, er);
    wen_cnt = 0;
    dmi_xfer(6'h17, 2'd2, 32'h00031005, rd, er);
    checks++;
    if (wen_cnt !== 1 || cap_addr !== 5'd5 || cap_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL gpr_write got cnt=%0d addr=%0d data=%h want 1 5 deadbeef", wen_cnt, cap_addr, cap_wdata);
    end
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL command_reads0 got %h want 0", rd); end
    dmi_xfer(6'h16, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL abstractcs_idle got %h want 00000000", rd); end
  endtask

  task automatic test_gpr_read();
    wen_cnt = 0;
    dmi_xfer(6'h17, 2'd2, 32'h0002100A, rd, er);
    dmi_xfer(6'h04, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h12345678 || wen_cnt !== 0) begin
      errors++; $display("FAIL gpr_read got %h wen=%0d want 12345678 wen=0", rd, wen_cnt);
    end
  endtask

  task automatic test_not_halted();
    dmi_xfer(6'h10, 2'd2, 32'h00000001, rd, er);
    wen_cnt = 0;
    dmi_xfer(6'h17, 2'd2, 32'h00021001, rd, er);
    dmi_xfer(6'h16, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h00000400 || wen_cnt !== 0) begin
      errors++; $display("FAIL cmderr_halt got %h wen=%0d want 00000400 wen=0", rd, wen_cnt);
    end
    dmi_xfer(6'h04, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL data0_kept got %h want 12345678", rd); end
    dmi_xfer(6'h16, 2'd2, 32'h00000700, rd, er);
    dmi_xfer(6'h16, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL cmderr_clear got %h want 00000000", rd); end
  endtask

  task automatic test_range_err();
    dmi_xfer(6'h10, 2'd2, 32'h80000001, rd, er);
    dmi_xfer(6'h04, 2'd2, 32'h11111111, rd, er);
    dmi_xfer(6'h17, 2'd2, 32'h00022000, rd, er);
    dmi_xfer(6'h16, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h00000200) begin errors++; $display("FAIL cmderr_range got %h want 00000200", rd); end
    // a valid command is dropped while cmderr is pending
    dmi_xfer(6'h17, 2'd2, 32'h0002100A, rd, er);
    dmi_xfer(6'h04, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h11111111) begin errors++; $display("FAIL cmd_ignored got %h want 11111111", rd); end
    dmi_xfer(6'h17, 2'd2, 32'h01021005, rd, er);
    dmi_xfer(6'h16, 2'd2, 32'h00000700, rd, er);
    dmi_xfer(6'h17, 2'd2, 32'h01021005, rd, er);
    dmi_xfer(6'h16, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h00000200) begin errors++; $display("FAIL cmderr_cmdtype got %h want 00000200", rd); end
    dmi_xfer(6'h16, 2'd2, 32'h00000700, rd, er);
  endtask

  task automatic test_ops();
    dmi_xfer(6'h3F, 2'd3, 32'd0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL op3_err got err %b data %h want 1 0", er, rd); end
    dmi_xfer(6'h04, 2'd0, 32'd0, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL nop got err %b data %h want 0 0", er, rd); end
    dmi_xfer(6'h05, 2'd2, 32'hFFFFFFFF, rd, er);
    dmi_xfer(6'h05, 2'd1, 32'd0, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL unmapped got err %b data %h want 0 0", er, rd); end
  endtask

  task automatic test_back_to_back();
    int nresp = 0, nrdy = 0;
    @(negedge clk);
    bus.dmi_resp_ready = 1'b1;
    bus.dmi_req_valid = 1'b1; bus.dmi_req_addr = 6'h11; bus.dmi_req_op = 2'd1; bus.dmi_req_data = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.dmi_resp_valid) nresp++;
      if (bus.dmi_req_ready) nrdy++;
    end
    bus.dmi_req_valid = 1'b0;
    @(negedge clk);
    bus.dmi_resp_ready = 1'b0;
    checks++;
    if (nresp !== 4 || nrdy !== 4) begin
      errors++; $display("FAIL back_to_back got resp=%0d ready=%0d want 4 4", nresp, nrdy);
    end
  endtask

  task automatic test_ndmreset();
    dmi_xfer(6'h10, 2'd2, 32'h00000003, rd, er);
    checks++;
    if (reset_req !== 1'b1 || halt_req !== 1'b0) begin
      errors++; $display("FAIL ndmreset got rst=%b halt=%b want 1 0", reset_req, halt_req);
    end
    dmi_xfer(6'h10, 2'd2, 32'h80000001, rd, er);
    dmi_xfer(6'h10, 2'd2, 32'h80000000, rd, er);
    checks++;
    if (halt_req !== 1'b0 || reset_req !== 1'b0) begin
      errors++; $display("FAIL dmactive0 got halt=%b rst=%b want 0 0", halt_req, reset_req);
    end
    dmi_xfer(6'h04, 2'd2, 32'hCAFEF00D, rd, er);
    dmi_xfer(6'h04, 2'd1, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL data0_inactive got %h want 00000000", rd); end
  endtask

  task automatic test_rst_mid();
    dmi_xfer(6'h10, 2'd2, 32'h80000001, rd, er);
    dmi_xfer(6'h04, 2'd2, 32'hA5A51234, rd, er);
    @(negedge clk);
    bus.dmi_req_valid = 1'b1; bus.dmi_req_addr = 6'h17; bus.dmi_req_op = 2'd2; bus.dmi_req_data = 32'h00031007;
    @(posedge clk); #1;
    bus.dmi_req_valid = 1'b0;
    checks++;
    if (reg_wen !== 1'b1 || reg_addr !== 5'd7 || reg_wdata !== 32'hA5A51234) begin
      errors++; $display("FAIL cacc_strobe got wen=%b addr=%0d data=%h want 1 7 a5a51234", reg_wen, reg_addr, reg_wdata);
    end
    wen_cnt = 0;
    rst = 1'b1; #1;
    checks++;
    if (reg_wen !== 1'b0 || reg_addr !== 5'd0 || reg_wdata !== 32'd0 || halt_req !== 1'b0) begin
      errors++; $display("FAIL rst_abort got wen=%b addr=%0d data=%h halt=%b want 0 0 0 0", reg_wen, reg_addr, reg_wdata, halt_req);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wen_cnt !== 0 || bus.dmi_req_ready !== 1'b1 || bus.dmi_resp_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst got wen=%0d ready=%b rv=%b want 0 1 0", wen_cnt, bus.dmi_req_ready, bus.dmi_resp_valid);
    end
  endtask

  initial begin
    bus.dmi_req_valid = 1'b0; bus.dmi_req_addr = '0; bus.dmi_req_op = 2'd0;
    bus.dmi_req_data = 32'd0; bus.dmi_resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_halt();
    test_gpr_write();
    test_gpr_read();
    test_not_halted();
    test_range_err();
    test_ops();
    test_back_to_back();
    test_ndmreset();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
